// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch-side instruction SRAM bridge.
//   state_t           : bridge FSM state encoding (IDLE / REQ / RESP)
//   RESET_PC          : first fetch address after reset
//   TIMEOUT_DEFAULT   : default cycles to wait for mem_ack before a bus error
//   ERR_INST_DEFAULT  : default instruction word returned on a timeout
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC         = 32'hbfc00000;
    localparam int unsigned TIMEOUT_DEFAULT  = 64;
    localparam logic [31:0] ERR_INST_DEFAULT = 32'h00000000;

endpackage

// File: rtl/inst_fetch_buf.sv
// -----------------------------------------------------------------------------
// inst_fetch_buf
// One-entry instruction buffer: a single {word address, instruction} pair.
//   clk            in   clock
//   resetn         in   synchronous active-low reset; invalidates the entry
//   i_lookup_word  in   word address (byte addr [31:2]) to compare
//   o_hit          out  combinational: entry valid and addresses match
//   o_data         out  buffered instruction word
//   i_fill         in   write the entry this edge
//   i_fill_word    in   word address to store
//   i_fill_data    in   instruction word to store
// -----------------------------------------------------------------------------
module inst_fetch_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic [29:0] i_lookup_word,
    output logic        o_hit,
    output logic [31:0] o_data,
    input  logic        i_fill,
    input  logic [29:0] i_fill_word,
    input  logic [31:0] i_fill_data
);

    logic        r_valid;
    logic [29:0] r_word;
    logic [31:0] r_data;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_word  <= '0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_word  <= i_fill_word;
            r_data  <= i_fill_data;
        end
    end

    assign o_hit  = r_valid && (r_word == i_lookup_word);
    assign o_data = r_data;

endmodule

// File: rtl/inst_sram_bridge.sv
// -----------------------------------------------------------------------------
// inst_sram_bridge
// Responder side of the fetch-stage instruction SRAM interface. Hits in the
// one-entry buffer return in one cycle; misses go to a variable-latency
// backing memory over mem_req/mem_ack while inst_sram_stall holds fetch.
// A miss that sees no ack within TIMEOUT cycles returns ERR_INST with err.
//   clk, resetn        clock, synchronous active-low reset
//   inst_sram_en       fetch request valid
//   inst_sram_addr     fetch byte address (bits [1:0] ignored)
//   inst_sram_rdata    instruction word (valid with rvalid)
//   inst_sram_rvalid   rdata valid for the last accepted address
//   inst_sram_stall    registered, high while a miss is outstanding
//   inst_sram_err      one-cycle pulse with rvalid after a timeout
//   mem_req/mem_addr   backing memory read request, held until ack
//   mem_ack/mem_rdata  backing memory read completion and data
// -----------------------------------------------------------------------------
module inst_sram_bridge
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_INST = ERR_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_rvalid,
    output logic        inst_sram_stall,
    output logic        inst_sram_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_rdata;
    logic               r_rvalid;
    logic               r_err;
    logic               r_mem_req;
    logic [29:0]        r_mem_word;
    logic [CNT_W-1:0]   r_cnt;

    logic [31:0]        w_rdata_nxt;
    logic               w_rvalid_nxt;
    logic               w_err_nxt;
    logic               w_mem_req_nxt;
    logic [29:0]        w_mem_word_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_fill;

    logic               w_hit;
    logic [31:0]        w_buf_data;
    logic               w_timeout;
    logic               w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^inst_sram_addr[1:0];
    assign w_timeout         = (r_cnt == CNT_W'(TIMEOUT - 1));

    inst_fetch_buf u_buf (
        .clk           (clk),
        .resetn        (resetn),
        .i_lookup_word (inst_sram_addr[31:2]),
        .o_hit         (w_hit),
        .o_data        (w_buf_data),
        .i_fill        (w_fill),
        .i_fill_word   (r_mem_word),
        .i_fill_data   (mem_rdata)
    );

    // State register; the interface outputs are registered alongside it so
    // none of them has a combinational path from the fetch inputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_word <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_err      <= w_err_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_word <= w_mem_word_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, RESP: begin
                if (inst_sram_en) begin
                    w_state_nxt = w_hit ? RESP : REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (mem_ack || w_timeout) begin
                    w_state_nxt = RESP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and buffer fill
    always_comb begin
        w_rdata_nxt    = r_rdata;
        w_rvalid_nxt   = 1'b0;
        w_err_nxt      = 1'b0;
        w_mem_req_nxt  = r_mem_req;
        w_mem_word_nxt = r_mem_word;
        w_cnt_nxt      = r_cnt;
        w_fill         = 1'b0;
        case (r_state)
            IDLE, RESP: begin
                w_mem_req_nxt = 1'b0;
                if (inst_sram_en) begin
                    if (w_hit) begin
                        w_rdata_nxt  = w_buf_data;
                        w_rvalid_nxt = 1'b1;
                    end else begin
                        w_mem_req_nxt  = 1'b1;
                        w_mem_word_nxt = inst_sram_addr[31:2];
                        w_cnt_nxt      = '0;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_rdata_nxt   = mem_rdata;
                    w_rvalid_nxt  = 1'b1;
                    w_fill        = 1'b1;
                end else if (w_timeout) begin
                    // Error word is returned but never cached.
                    w_mem_req_nxt = 1'b0;
                    w_rdata_nxt   = ERR_INST;
                    w_rvalid_nxt  = 1'b1;
                    w_err_nxt     = 1'b1;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    assign inst_sram_stall  = (r_state == REQ);
    assign inst_sram_rdata  = r_rdata;
    assign inst_sram_rvalid = r_rvalid;
    assign inst_sram_err    = r_err;
    assign mem_req          = r_mem_req;
    assign mem_addr         = {r_mem_word, 2'b00};

endmodule

// File: tb/tb_inst_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_inst_sram_bridge
// Self-checking bench for inst_sram_bridge: a directed vector table, a few
// hand-written multi-cycle sequences, then randomized traffic compared with
// a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_inst_sram_bridge;
    import cpu_pkg::*;

    localparam int unsigned TO   = 8;
    localparam logic [31:0] ERRW = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic [31:0] addr = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
    logic        err;
    logic        mem_req;
    logic [31:0] mem_addr;

    always #5 clk = ~clk;

    inst_sram_bridge #(.TIMEOUT(TO), .ERR_INST(ERRW)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .inst_sram_en     (en),
        .inst_sram_addr   (addr),
        .inst_sram_rdata  (rdata),
        .inst_sram_rvalid (rvalid),
        .inst_sram_stall  (stall),
        .inst_sram_err    (err),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    logic        m_pend;      // a miss is outstanding at the backing memory
    int          m_reqcyc;    // how many cycles the outstanding miss has waited
    logic        m_bv;
    logic [29:0] m_bword;
    logic [31:0] m_bdata;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [31:0] m_maddr;

    task automatic model_step(input logic rs, input logic e, input logic [31:0] a,
                              input logic ack, input logic [31:0] rd);
        m_rvalid = 1'b0;
        m_err    = 1'b0;
        if (!rs) begin
            m_pend = 1'b0; m_reqcyc = 0; m_bv = 1'b0; m_bword = '0;
            m_bdata = '0; m_rdata = '0; m_maddr = '0;
        end else if (m_pend) begin
            if (ack) begin
                m_rvalid = 1'b1; m_rdata = rd; m_pend = 1'b0;
                m_bv = 1'b1; m_bword = m_maddr[31:2]; m_bdata = rd;
            end else if (m_reqcyc == int'(TO)) begin
                m_rvalid = 1'b1; m_rdata = ERRW; m_err = 1'b1; m_pend = 1'b0;
            end else begin
                m_reqcyc++;
            end
        end else if (e) begin
            if (m_bv && m_bword == a[31:2]) begin
                m_rvalid = 1'b1; m_rdata = m_bdata;
            end else begin
                m_pend = 1'b1; m_reqcyc = 1; m_maddr = {a[31:2], 2'b00};
            end
        end
    endtask

    // One clock: inputs applied at the falling edge, outputs sampled #1 after
    // the rising edge.
    task automatic drive(input logic rs, input logic e, input logic [31:0] a,
                         input logic ack, input logic [31:0] rd);
        @(negedge clk);
        resetn = rs; en = e; addr = a; mem_ack = ack; mem_rdata = rd;
        @(posedge clk);
        #1;
        model_step(rs, e, a, ack, rd);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rs;
        logic        e;
        logic [31:0] a;
        logic        ack;
        logic [31:0] rd;
        logic        x_stall;
        logic        x_req;
        logic [31:0] x_maddr;
        logic        x_rvalid;
        logic [31:0] x_rdata;
        logic        x_err;
    } vec_t;

    function automatic vec_t V(input logic rs, input logic e, input logic [31:0] a,
                               input logic ack, input logic [31:0] rd,
                               input logic xs, input logic xq, input logic [31:0] xm,
                               input logic xv, input logic [31:0] xd, input logic xe);
        vec_t v;
        v.rs = rs; v.e = e; v.a = a; v.ack = ack; v.rd = rd;
        v.x_stall = xs; v.x_req = xq; v.x_maddr = xm;
        v.x_rvalid = xv; v.x_rdata = xd; v.x_err = xe;
        return v;
    endfunction

    localparam logic [31:0] A  = RESET_PC;
    localparam logic [31:0] B  = 32'hbfc00010;
    localparam logic [31:0] C  = 32'h80001000;
    localparam logic [31:0] D1 = 32'hA1B2C3D4;
    localparam logic [31:0] D2 = 32'h0BADF00D;
    localparam logic [31:0] D3 = 32'hFFFF0000;
    localparam logic [31:0] D4 = 32'h76543210;

    vec_t tbl[$];

    initial begin
        int req_cycles;
        int lat;
        logic        r_rs, r_e, r_ack;
        logic [31:0] r_a, r_rd, last_a;

        m_pend = 1'b0; m_reqcyc = 0; m_bv = 1'b0; m_bword = '0; m_bdata = '0;
        m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0; m_maddr = '0;

        //            rs e  addr        ack rdata  stall req maddr  rv rdata err
        tbl.push_back(V(0, 0, 32'h0,       0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0));
        tbl.push_back(V(0, 0, 32'h0,       0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0));
        tbl.push_back(V(1, 1, A,           0, 32'h0, 1, 1, A,     0, 32'h0, 0));
        tbl.push_back(V(1, 1, A,           0, 32'h0, 1, 1, A,     0, 32'h0, 0));
        tbl.push_back(V(1, 1, A,           0, 32'h0, 1, 1, A,     0, 32'h0, 0));
        tbl.push_back(V(1, 1, A,           1, D1,    0, 0, A,     1, D1,    0));
        tbl.push_back(V(1, 1, 32'hbfc00002,0, 32'h0, 0, 0, A,     1, D1,    0));
        tbl.push_back(V(1, 0, 32'h0,       0, 32'h0, 0, 0, A,     0, D1,    0));
        tbl.push_back(V(1, 0, 32'h0,       1, D3,    0, 0, A,     0, D1,    0));
        tbl.push_back(V(1, 0, 32'h0,       0, 32'h0, 0, 0, A,     0, D1,    0));
        tbl.push_back(V(1, 1, 32'hbfc00003,0, 32'h0, 0, 0, A,     1, D1,    0));
        tbl.push_back(V(1, 1, B,           0, 32'h0, 1, 1, B,     0, D1,    0));
        tbl.push_back(V(1, 0, 32'h123,     0, 32'h0, 1, 1, B,     0, D1,    0));
        tbl.push_back(V(1, 1, B,           1, D2,    0, 0, B,     1, D2,    0));
        tbl.push_back(V(1, 1, A,           0, 32'h0, 1, 1, A,     0, D2,    0));
        tbl.push_back(V(0, 1, A,           0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0));
        tbl.push_back(V(1, 0, 32'h0,       0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0));
        tbl.push_back(V(1, 0, 32'h0,       1, D3,    0, 0, 32'h0, 0, 32'h0, 0));
        tbl.push_back(V(1, 0, 32'h0,       0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0));
        tbl.push_back(V(1, 1, B,           0, 32'h0, 1, 1, B,     0, 32'h0, 0));
        tbl.push_back(V(1, 1, B,           1, D4,    0, 0, B,     1, D4,    0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rs, tbl[i].e, tbl[i].a, tbl[i].ack, tbl[i].rd);
            chk($sformatf("vec%0d stall", i),    {31'b0, stall},  {31'b0, tbl[i].x_stall});
            chk($sformatf("vec%0d mem_req", i),  {31'b0, mem_req},{31'b0, tbl[i].x_req});
            chk($sformatf("vec%0d mem_addr", i), mem_addr,        tbl[i].x_maddr);
            chk($sformatf("vec%0d rvalid", i),   {31'b0, rvalid}, {31'b0, tbl[i].x_rvalid});
            chk($sformatf("vec%0d rdata", i),    rdata,           tbl[i].x_rdata);
            chk($sformatf("vec%0d err", i),      {31'b0, err},    {31'b0, tbl[i].x_err});
        end

        // ---------------- zero-latency memory, back-to-back misses ----------
        drive(0, 0, 32'h0, 0, 32'h0);
        drive(1, 1, A, 0, 32'h0);
        chk("b2b miss0 stall", {31'b0, stall}, 32'd1);
        chk("b2b miss0 addr", mem_addr, A);
        drive(1, 1, A, 1, memword(A));
        chk("b2b resp0 rvalid", {31'b0, rvalid}, 32'd1);
        chk("b2b resp0 rdata", rdata, memword(A));
        chk("b2b resp0 req", {31'b0, mem_req}, 32'd0);
        drive(1, 1, A + 32'd4, 0, 32'h0);
        chk("b2b miss1 req", {31'b0, mem_req}, 32'd1);
        chk("b2b miss1 addr", mem_addr, A + 32'd4);
        chk("b2b miss1 rvalid", {31'b0, rvalid}, 32'd0);
        drive(1, 1, A + 32'd4, 1, memword(A + 32'd4));
        chk("b2b resp1 rdata", rdata, memword(A + 32'd4));
        chk("b2b resp1 stall", {31'b0, stall}, 32'd0);
        drive(1, 0, 32'h0, 0, 32'h0);
        chk("b2b idle rvalid", {31'b0, rvalid}, 32'd0);

        // ---------------- timeout ----------------
        drive(0, 0, 32'h0, 0, 32'h0);
        drive(1, 1, C, 0, 32'h0);
        req_cycles = 0;
        for (int k = 0; k < 20 && mem_req; k++) begin
            req_cycles++;
            drive(1, 1, C, 0, 32'h0);
        end
        chk("timeout req cycles", 32'(req_cycles), 32'(TO));
        chk("timeout rvalid", {31'b0, rvalid}, 32'd1);
        chk("timeout err", {31'b0, err}, 32'd1);
        chk("timeout rdata", rdata, ERRW);
        chk("timeout stall", {31'b0, stall}, 32'd0);
        drive(1, 0, 32'h0, 1, 32'h55555555);
        chk("late ack err", {31'b0, err}, 32'd0);
        chk("late ack rvalid", {31'b0, rvalid}, 32'd0);
        chk("late ack req", {31'b0, mem_req}, 32'd0);
        drive(1, 1, C, 0, 32'h0);
        chk("after timeout miss", {31'b0, stall}, 32'd1);
        drive(1, 1, C, 1, memword(C));
        chk("after timeout rdata", rdata, memword(C));
        chk("after timeout err", {31'b0, err}, 32'd0);

        // ---------------- randomized traffic vs. model ----------------
        drive(0, 0, 32'h0, 0, 32'h0);
        last_a = A;
        lat = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            r_rs = ($urandom_range(0, 299) != 0);
            if (m_pend) begin
                r_e   = ($urandom_range(0, 1) == 1);
                r_a   = $urandom;
                r_ack = (lat >= 0) && (m_reqcyc == lat + 1);
            end else begin
                r_e = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) != 0)
                    r_a = A + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
                else
                    r_a = last_a;
                last_a = r_a;
                r_ack = ($urandom_range(0, 9) == 0);
            end
            r_rd = (r_ack && m_pend) ? memword(mem_addr) : $urandom;
            drive(r_rs, r_e, r_a, r_ack, r_rd);
            if (m_pend && m_reqcyc == 1)
                lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
            chk($sformatf("rnd%0d stall", cyc),   {31'b0, stall},   {31'b0, m_pend});
            chk($sformatf("rnd%0d mem_req", cyc), {31'b0, mem_req}, {31'b0, m_pend});
            chk($sformatf("rnd%0d rvalid", cyc),  {31'b0, rvalid},  {31'b0, m_rvalid});
            chk($sformatf("rnd%0d err", cyc),     {31'b0, err},     {31'b0, m_err});
            if (m_rvalid)
                chk($sformatf("rnd%0d rdata", cyc), rdata, m_rdata);
            if (m_pend)
                chk($sformatf("rnd%0d mem_addr", cyc), mem_addr, m_maddr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/inst_sram_bridge.md
Name: inst_sram_bridge

Overview:
Responder end of the fetch-stage instruction SRAM interface (inst_sram_en / inst_sram_addr). It accepts one fetch address per cycle and returns the instruction word, serving hits from a one-entry buffer in 1 cycle. Misses are forwarded to a variable-latency backing memory over a req/ack handshake, and inst_sram_stall is raised so fetch holds its PC. It sits between fetch_stage and the memory/bus adapter.

Parameters:
TIMEOUT, 64, max cycles to wait for mem_ack before aborting with a bus error
ERR_INST, 32'h00000000, instruction word returned on timeout

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
inst_sram_en  in  1  fetch request valid this cycle
inst_sram_addr  in  32  fetch byte address; bits [1:0] ignored
inst_sram_rdata  out  32  instruction word, meaningful when inst_sram_rvalid=1
inst_sram_rvalid  out  1  rdata valid this cycle for the last accepted address
inst_sram_stall  out  1  registered; fetch must hold its address while 1
inst_sram_err  out  1  one-cycle pulse with rvalid on timeout
mem_req  out  1  backing memory read request, held until ack
mem_addr  out  32  word address {addr[31:2],2'b00}, stable while mem_req=1
mem_ack  in  1  backing memory read done, valid for one cycle
mem_rdata  in  32  read data, sampled when mem_ack=1

Behaviour:
- Reset values: state=IDLE, all outputs 0, buffer invalid (buf_valid=0, buf_addr=0, buf_data=0), wait counter 0.
- Stall is registered from state: stall=1 iff state is REQ. There is no combinational path from inst_sram_en/addr to stall. This avoids a loop with fetch's stall-muxed address.
- An address is "accepted" at a clock edge when inst_sram_en=1 and the state is IDLE or RESP.
- Accepting state (IDLE or RESP), en=1:
  - Hit (buf_valid && buf_addr[31:2]==addr[31:2]): next state RESP; rdata<=buf_data; rvalid<=1. Total latency 1 cycle.
  - Miss: next state REQ; mem_req<=1; mem_addr<=word address; latch the request address; counter<=0; rvalid<=0.
- Accepting state, en=0: next state IDLE, rvalid<=0.
- REQ:
  - stall=1, mem_req=1, mem_addr held. inst_sram_en and inst_sram_addr are ignored; fetch re-presents the same address.
  - mem_ack=1: mem_req<=0; rdata<=mem_rdata; rvalid<=1; buffer<={1, req addr, mem_rdata}; next state RESP. Miss latency = ack cycle + 1.
  - No ack and counter==TIMEOUT-1: mem_req<=0; rdata<=ERR_INST; rvalid<=1; err<=1; buffer not updated; next state RESP.
  - Otherwise counter increments; the counter saturates and does not wrap.
- RESP: stall=0, rvalid=1 for exactly this cycle. Fetch advances. A back-to-back accept is allowed in the same edge (see accepting-state rules).
- mem_ack while not in REQ (stray, or arriving after a timeout): ignored, no state or data change.
- Reset mid-miss: mem_req drops at the reset edge, buffer invalidated, state IDLE. A later mem_ack is ignored.
- inst_sram_err is high only in the RESP cycle that follows a timeout.

Decomposition:
- Shared package (cpu_pkg): state encoding IDLE=2'd0, REQ=2'd1, RESP=2'd2; RESET_PC=32'hbfc00000 for the testbench; default TIMEOUT.
- One natural sub-module, inst_fetch_buf: holds buf_valid/buf_addr/buf_data. It provides the combinational hit compare, a synchronous fill port and an invalidate on resetn.

Test Plan:
1. Reset, then en=1, addr=32'hbfc00000, memory latency 3 -> stall high cycles 1-3, mem_req high until ack, mem_addr=bfc00000; rvalid=1, rdata=mem word, stall=0 in the cycle after ack.
2. Repeat the same address bfc00002 immediately after RESP -> hit: no mem_req, rvalid=1 next cycle with buffered data, stall stays 0.
3. Sequential addresses bfc00000, bfc00004 back-to-back with 0-latency memory (ack in the first REQ cycle) -> two misses, each 2 cycles; no lost or duplicated requests; rdata in order.
4. Memory never acks, TIMEOUT=8 -> mem_req high for 8 cycles and then drops; RESP shows rdata=ERR_INST, err=1 for one cycle, buffer still invalid (next same-address access misses).
5. resetn low during the REQ wait, ack arrives 2 cycles after reset releases -> ack ignored; outputs stay 0 and state IDLE until a new en.
6. en=0 for several cycles after RESP -> rvalid=0, stall=0, mem_req=0, buffer contents retained (a later same-address access hits).
